// File: rtl/pc_stack_seq.sv
// pc_stack_seq: program-counter sequencer with branches, call/return stack, stall and sticky stack errors
//   i_clk       clock, all state updates on the rising edge
//   i_reset     synchronous active-high reset, beats stall and op
//   i_stall     hold every piece of state this cycle
//   i_pc_op     000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, others behave as INC
//   i_jump_addr absolute target for JUMP and CALL
//   i_offset    signed branch offset relative to the current pc
//   i_cond      branch taken when high
//   o_pc        registered program counter / instruction address
//   o_depth     number of occupied return-stack entries
//   o_stack_ovf sticky, CALL seen with the stack full
//   o_stack_unf sticky, RET seen with the stack empty
module pc_stack_seq #(
    parameter int PC_W        = 10,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_ADDR  = 0
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_stall,
    input  logic [2:0]                         i_pc_op,
    input  logic [PC_W-1:0]                    i_jump_addr,
    input  logic [OFF_W-1:0]                   i_offset,
    input  logic                               i_cond,
    output logic [PC_W-1:0]                    o_pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_depth,
    output logic                               o_stack_ovf,
    output logic                               o_stack_unf
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);
    logic [PC_W-1:0] r_pc;
    logic [DW-1:0]   r_depth;
    logic            r_ovf;
    logic            r_unf;
    logic [PC_W-1:0] r_stack [STACK_DEPTH];
    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_off;
    logic [PC_W-1:0] w_pc_nxt;
    logic [DW-1:0]   w_depth_nxt;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_rd_idx;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_unf_set;
    // A size cast of a signed value sign-extends; the add then wraps modulo 2^PC_W.
    assign w_off    = PC_W'($signed(i_offset));
    assign w_inc    = r_pc + PC_W'(1);
    assign w_full   = r_depth == DW'(STACK_DEPTH);
    assign w_empty  = r_depth == '0;
    // Both indices are only used when in range (push when not full, pop when not empty).
    assign w_wr_idx = AW'(r_depth);
    assign w_rd_idx = AW'(r_depth - DW'(1));
    always_comb begin
        w_pc_nxt    = w_inc;
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (i_pc_op)
            3'd1: w_pc_nxt = i_jump_addr;
            3'd2: w_pc_nxt = i_cond ? r_pc + w_off : w_inc;
            3'd3: begin
                w_ovf_set   = w_full;
                w_push      = !w_full;
                w_depth_nxt = w_full ? r_depth : r_depth + DW'(1);
                w_pc_nxt    = w_full ? w_inc : i_jump_addr;
            end
            3'd4: begin
                w_unf_set   = w_empty;
                w_depth_nxt = w_empty ? r_depth : r_depth - DW'(1);
                w_pc_nxt    = w_empty ? w_inc : r_stack[w_rd_idx];
            end
            default: w_pc_nxt = w_inc;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc    <= PC_W'(RESET_ADDR);
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!i_stall) begin
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
        end
    end
    // Stack contents need no reset; depth alone defines what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_stall && w_push)
            r_stack[w_wr_idx] <= w_inc;
    end
    assign o_pc        = r_pc;
    assign o_depth     = r_depth;
    assign o_stack_ovf = r_ovf;
    assign o_stack_unf = r_unf;
endmodule
